// File: rtl/mod_clkgen_multiphase.sv
// Multi-phase bucket-modulation clock generator: one programmable-period counter
// drives NUM_CH windowed outputs plus a 50% reference, with shadowed config and overlap blanking.
module mod_clkgen_multiphase #(
  parameter int unsigned CNT_W  = 17,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                    CLK_IN,
  input  logic                    RST,
  input  logic                    DRAIN_B,
  input  logic                    CFG_LOAD,
  input  logic [CNT_W-1:0]        PERIOD,
  input  logic [NUM_CH*CNT_W-1:0] START,
  input  logic [NUM_CH*CNT_W-1:0] WIDTH,
  output logic [NUM_CH-1:0]       CLK_OUT_MOD,
  output logic                    CLK_OUT_MODL,
  output logic                    FRAME_STROBE,
  output logic                    OVERLAP_ERR,
  output logic                    CFG_PENDING
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          act_period;
  logic [NUM_CH*CNT_W-1:0]   act_start;
  logic [NUM_CH*CNT_W-1:0]   act_width;
  logic [CNT_W-1:0]          period_clamped;
  logic [NUM_CH-1:0]         win;
  logic                      overlap;
  logic                      wrap;
  logic [CNT_W:0]            s, w, e, p, c;

  assign period_clamped = (PERIOD < CNT_W'(2)) ? CNT_W'(2) : PERIOD;
  assign wrap           = (cnt == act_period - CNT_W'(1));

  // Window arithmetic is done one bit wider so start+width cannot overflow.
  always_comb begin
    win = '0;
    s   = '0;
    w   = '0;
    e   = '0;
    p   = {1'b0, act_period};
    c   = {1'b0, cnt};
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      s = {1'b0, act_start[k*CNT_W +: CNT_W]};
      w = {1'b0, act_width[k*CNT_W +: CNT_W]};
      e = s + w;
      if (w == '0 || s >= p)
        win[k] = 1'b0;
      else if (w >= p)
        win[k] = 1'b1;
      else
        win[k] = (c >= s && c < e) || (e > p && c < e - p);
    end
  end

  assign overlap = (win & (win - NUM_CH'(1))) != '0;

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= '0;
      CLK_OUT_MOD  <= '0;
      CLK_OUT_MODL <= 1'b0;
      FRAME_STROBE <= 1'b0;
      OVERLAP_ERR  <= 1'b0;
      CFG_PENDING  <= 1'b1;
      act_period   <= '0;
      act_start    <= '0;
      act_width    <= '0;
    end else begin
      case (state)
        IDLE: begin
          act_period  <= period_clamped;
          act_start   <= START;
          act_width   <= WIDTH;
          CFG_PENDING <= 1'b0;
          OVERLAP_ERR <= 1'b0;
          state       <= DRAIN_B ? RUN : DRAIN;
        end
        RUN: begin
          if (!DRAIN_B) begin
            state        <= DRAIN;
            CLK_OUT_MOD  <= '1;
            CLK_OUT_MODL <= 1'b0;
            FRAME_STROBE <= 1'b0;
            cnt          <= '0;
          end else begin
            CLK_OUT_MOD  <= overlap ? '0 : win;
            CLK_OUT_MODL <= (cnt < (act_period >> 1));
            FRAME_STROBE <= wrap;
            cnt          <= wrap ? '0 : cnt + CNT_W'(1);
            if (overlap)
              OVERLAP_ERR <= 1'b1;
            // Transfer clear is placed after the overlap set so a transfer always wins.
            if (wrap && (CFG_PENDING || CFG_LOAD)) begin
              act_period  <= period_clamped;
              act_start   <= START;
              act_width   <= WIDTH;
              CFG_PENDING <= 1'b0;
              OVERLAP_ERR <= 1'b0;
            end else if (CFG_LOAD) begin
              CFG_PENDING <= 1'b1;
            end
          end
        end
        DRAIN: begin
          act_period   <= period_clamped;
          act_start    <= START;
          act_width    <= WIDTH;
          CFG_PENDING  <= 1'b0;
          OVERLAP_ERR  <= 1'b0;
          CLK_OUT_MODL <= 1'b0;
          FRAME_STROBE <= 1'b0;
          cnt          <= '0;
          if (DRAIN_B) begin
            state       <= RUN;
            CLK_OUT_MOD <= '0;
          end else begin
            CLK_OUT_MOD <= '1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_clkgen_multiphase.sv
// Bench for mod_clkgen_multiphase: modular-arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mod_clkgen_multiphase;
  localparam int CW  = 8;
  localparam int NCH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          drain_b = 1'b1;
  logic          cfg_load = 1'b0;
  logic [CW-1:0] period = 8'd8;
  logic [NCH*CW-1:0] start = {8'd4, 8'd0};
  logic [NCH*CW-1:0] width = {8'd3, 8'd3};
  logic [NCH-1:0] mod;
  logic          modl, strobe, ovl, pend;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_clkgen_multiphase #(.CNT_W(CW), .NUM_CH(NCH)) dut (
    .CLK_IN      (clk),
    .RST         (rst),
    .DRAIN_B     (drain_b),
    .CFG_LOAD    (cfg_load),
    .PERIOD      (period),
    .START       (start),
    .WIDTH       (width),
    .CLK_OUT_MOD (mod),
    .CLK_OUT_MODL(modl),
    .FRAME_STROBE(strobe),
    .OVERLAP_ERR (ovl),
    .CFG_PENDING (pend)
  );

  // Reference model: 0 = idle, 1 = running, 2 = draining
  int             m_state = 0;
  int             m_cnt   = 0;
  int             m_p     = 2;
  int             m_start [NCH];
  int             m_width [NCH];
  logic [NCH-1:0] e_mod    = '0;
  logic           e_modl   = 1'b0;
  logic           e_strobe = 1'b0;
  logic           e_ovl    = 1'b0;
  logic           e_pend   = 1'b1;

  // A channel is high when the distance from its start, modulo the period, is below its width.
  function automatic logic [NCH-1:0] model_win();
    logic [NCH-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) begin
      if (m_width[k] == 0 || m_start[k] >= m_p) v[k] = 1'b0;
      else if (m_width[k] >= m_p)               v[k] = 1'b1;
      else v[k] = ((m_cnt - m_start[k] + m_p) % m_p) < m_width[k];
    end
    return v;
  endfunction

  function automatic bit model_load_now();
    return (m_state != 1) ||
           (drain_b && (m_cnt == m_p - 1) && (e_pend || cfg_load));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state  <= 0;
      m_cnt    <= 0;
      m_p      <= 2;
      e_mod    <= '0;
      e_modl   <= 1'b0;
      e_strobe <= 1'b0;
      e_ovl    <= 1'b0;
      e_pend   <= 1'b1;
      for (int k = 0; k < NCH; k++) begin
        m_start[k] <= 0;
        m_width[k] <= 0;
      end
    end else begin
      if (model_load_now()) begin
        m_p    <= (period < 2) ? 2 : int'(period);
        e_pend <= 1'b0;
        for (int k = 0; k < NCH; k++) begin
          m_start[k] <= int'(start[k*CW +: CW]);
          m_width[k] <= int'(width[k*CW +: CW]);
        end
      end
      case (m_state)
        0: begin
          m_state <= drain_b ? 1 : 2;
          e_ovl   <= 1'b0;
        end
        1: begin
          if (!drain_b) begin
            m_state  <= 2;
            e_mod    <= '1;
            e_modl   <= 1'b0;
            e_strobe <= 1'b0;
            m_cnt    <= 0;
          end else begin
            e_mod    <= ($countones(model_win()) > 1) ? '0 : model_win();
            e_modl   <= m_cnt < (m_p / 2);
            e_strobe <= (m_cnt == m_p - 1);
            m_cnt    <= (m_cnt + 1) % m_p;
            if (model_load_now())                   e_ovl <= 1'b0;
            else if ($countones(model_win()) > 1)   e_ovl <= 1'b1;
            if (cfg_load && !model_load_now())      e_pend <= 1'b1;
          end
        end
        default: begin
          e_mod    <= drain_b ? '0 : '1;
          e_modl   <= 1'b0;
          e_strobe <= 1'b0;
          e_ovl    <= 1'b0;
          m_cnt    <= 0;
          if (drain_b) m_state <= 1;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_mod",    32'(mod),    32'(e_mod));
    chk("cyc_modl",   32'(modl),   32'(e_modl));
    chk("cyc_strobe", 32'(strobe), 32'(e_strobe));
    chk("cyc_ovl",    32'(ovl),    32'(e_ovl));
    chk("cyc_pend",   32'(pend),   32'(e_pend));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_xfer(input string name);
    int n;
    n = 0;
    while (pend && n < 20) begin
      step(1);
      n++;
    end
    chk(name, 32'(pend), 32'd0);
  endtask

  // Starts right after reset release with P=8, START={4,0}, WIDTH={3,3}.
  task automatic scen1_checks(input string tag);
    step(1); chk({tag, "_e1_mod"}, 32'(mod), 32'd0); chk({tag, "_e1_pend"}, 32'(pend), 32'd0);
    step(1); chk({tag, "_e2_mod"}, 32'(mod), 32'd1); chk({tag, "_e2_modl"}, 32'(modl), 32'd1);
    chk({tag, "_model_e2_mod"}, 32'(e_mod), 32'd1);
    step(3); chk({tag, "_e5_mod"}, 32'(mod), 32'd0); chk({tag, "_e5_modl"}, 32'(modl), 32'd1);
    step(1); chk({tag, "_e6_mod"}, 32'(mod), 32'd2); chk({tag, "_e6_modl"}, 32'(modl), 32'd0);
    chk({tag, "_model_e6_mod"}, 32'(e_mod), 32'd2);
    step(3); chk({tag, "_e9_strobe"}, 32'(strobe), 32'd1); chk({tag, "_e9_mod"}, 32'(mod), 32'd0);
    chk({tag, "_model_e9_strobe"}, 32'(e_strobe), 32'd1);
    step(1); chk({tag, "_e10_mod"}, 32'(mod), 32'd1); chk({tag, "_e10_strobe"}, 32'(strobe), 32'd0);
    chk({tag, "_e10_ovl"}, 32'(ovl), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mod", 32'(mod), 32'd0);
    chk("rst_modl", 32'(modl), 32'd0);
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk("rst_ovl", 32'(ovl), 32'd0);
    chk("rst_pend", 32'(pend), 32'd1);
    rst = 1'b0;
    scen1_checks("s1");

    // Window wrapping across the period boundary
    start = {8'd6, 8'd2}; width = {8'd4, 8'd3};
    cfg_load = 1'b1; step(1); cfg_load = 1'b0;
    chk("s2_pend_set", 32'(pend), 32'd1);
    wait_xfer("s2_xfer");
    chk("s2_xfer_strobe", 32'(strobe), 32'd1);
    step(1); chk("s2_c0_mod", 32'(mod), 32'd2);
    step(1); chk("s2_c1_mod", 32'(mod), 32'd2);
    step(1); chk("s2_c2_mod", 32'(mod), 32'd1);
    step(5); chk("s2_c7_mod", 32'(mod), 32'd2); chk("s2_c7_strobe", 32'(strobe), 32'd1);
    step(16); chk("s2_ovl", 32'(ovl), 32'd0);

    // Overlapping windows blank both channels
    start = {8'd2, 8'd2}; width = {8'd3, 8'd3};
    cfg_load = 1'b1; step(1); cfg_load = 1'b0;
    wait_xfer("s3_xfer");
    step(3); chk("s3_c2_mod", 32'(mod), 32'd0); chk("s3_c2_ovl", 32'(ovl), 32'd1);
    step(13); chk("s3_sticky_ovl", 32'(ovl), 32'd1);
    start = {8'd4, 8'd0}; width = {8'd3, 8'd3};
    cfg_load = 1'b1; step(1); cfg_load = 1'b0;
    chk("s3_sticky_pending", 32'(ovl), 32'd1);
    wait_xfer("s3_clear_xfer");
    chk("s3_clear_ovl", 32'(ovl), 32'd0); chk("s3_xfer_mod", 32'(mod), 32'd0);
    step(1); chk("s3_clean_mod", 32'(mod), 32'd1);

    // Period change requested mid-period; inputs sampled at the wrap
    step(2);
    cfg_load = 1'b1; step(1); cfg_load = 1'b0;
    chk("s4_pend_c3", 32'(pend), 32'd1);
    period = 8'd12; start = {8'd6, 8'd1}; width = {8'd4, 8'd2};
    step(3); chk("s4_pend_c6", 32'(pend), 32'd1);
    step(1); chk("s4_pend_c7", 32'(pend), 32'd0); chk("s4_strobe_c7", 32'(strobe), 32'd1);
    step(2); chk("s4_c1_mod", 32'(mod), 32'd1);
    step(6); chk("s4_c7_strobe", 32'(strobe), 32'd0); chk("s4_c7_mod", 32'(mod), 32'd2);
    step(4); chk("s4_c11_strobe", 32'(strobe), 32'd1); chk("s4_c11_mod", 32'(mod), 32'd0);
    step(11);
    period = 8'd8; start = {8'd4, 8'd0}; width = {8'd3, 8'd3};
    cfg_load = 1'b1; step(1); cfg_load = 1'b0;
    chk("s4_coinc_pend", 32'(pend), 32'd0); chk("s4_coinc_strobe", 32'(strobe), 32'd1);
    step(1); chk("s4_coinc_mod", 32'(mod), 32'd1);

    // Drain entered at cnt 5 for four edges
    step(4);
    drain_b = 1'b0;
    step(1); chk("s5_drain_mod", 32'(mod), 32'd3); chk("s5_drain_modl", 32'(modl), 32'd0);
    step(3); chk("s5_hold_mod", 32'(mod), 32'd3); chk("s5_hold_strobe", 32'(strobe), 32'd0);
    drain_b = 1'b1;
    step(1); chk("s5_rel_mod", 32'(mod), 32'd0);
    step(1); chk("s5_c0_mod", 32'(mod), 32'd1);
    step(2); chk("s5_c2_mod", 32'(mod), 32'd1);
    step(1); chk("s5_c3_mod", 32'(mod), 32'd0);

    // Asynchronous reset between edges
    step(1); chk("s6_pre_mod", 32'(mod), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("s6_async_mod", 32'(mod), 32'd0);
    chk("s6_async_modl", 32'(modl), 32'd0);
    chk("s6_async_strobe", 32'(strobe), 32'd0);
    chk("s6_async_pend", 32'(pend), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    scen1_checks("s6");
    step(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
